// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants, widths and colour types for the VGA sync generator.
// Default timing is standard 640x480@60 (800 x 525 total, 25.175 MHz pixel clock).
// The test-pattern helpers (bar colour table, bar index decode) are only
// referenced when the top is built with VGA_SYNC_TEST_PATTERN_EN defined.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W     = 10;
    localparam int COORD_X_W = 10;
    localparam int COORD_Y_W = 9;
    localparam int COLOR_W   = 4;

    localparam int BAR_W    = 80;
    localparam int NUM_BARS = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Raw timing flags that travel together through the alignment delay line.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } align_t;

    // Classic bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 4'hF, g: 4'hF, b: 4'hF};
            3'd1:    c = '{r: 4'hF, g: 4'hF, b: 4'h0};
            3'd2:    c = '{r: 4'h0, g: 4'hF, b: 4'hF};
            3'd3:    c = '{r: 4'h0, g: 4'hF, b: 4'h0};
            3'd4:    c = '{r: 4'hF, g: 4'h0, b: 4'hF};
            3'd5:    c = '{r: 4'hF, g: 4'h0, b: 4'h0};
            3'd6:    c = '{r: 4'h0, g: 4'h0, b: 4'hF};
            default: c = '{r: 4'h0, g: 4'h0, b: 4'h0};
        endcase
        return c;
    endfunction

    // x/80 via a compare chain; scanning downwards leaves the narrowest matching bar.
    function automatic logic [2:0] bar_index(input logic [COORD_X_W-1:0] x);
        logic [2:0] idx;
        idx = 3'(NUM_BARS - 1);
        for (int i = NUM_BARS - 2; i >= 0; i--) begin
            if (x < COORD_X_W'(BAR_W * (i + 1))) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One timing axis (horizontal or vertical): a wrapping position counter with
// enable, plus combinational decode of the wrap strobe, active region and sync
// region. Region order along the axis is ACTIVE, FP, SYNC, BP.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset, clears the count
//   enable   in   advance the count this cycle
//   count    out  current position 0..TOTAL-1
//   wrap     out  high when enabled and count is at TOTAL-1 (count returns to 0 next edge)
//   active   out  count in [0, ACTIVE)
//   sync     out  count in [ACTIVE+FP, ACTIVE+FP+SYNC)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign wrap   = enable && (count == LAST);
    assign active = count < ACTIVE_END;
    assign sync   = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Generates VGA timing (640x480@60 by default) from the pixel clock, hands the
// current pixel coordinate to the renderer and drives the VGA pins with the
// renderer's colour. Sync and blanking are delayed to line up with the
// renderer's registered colour so all pin signals leave on the same edge.
// Ports:
//   vga_clock            in   pixel clock, rising edge
//   reset_n              in   synchronous active-low reset
//   screenX / screenY    out  active pixel coordinate, 0 during blanking (registered)
//   refresh              out  one-cycle pulse at the start of vertical blank
//   r_in / g_in / b_in   in   renderer colour, valid PIPE_DELAY cycles after the coordinate
//   vga_r / vga_g / vga_b out pin colour, 0 outside active video
//   vga_hs / vga_vs      out  sync pins, asserted level SYNC_POL
// Build option: VGA_SYNC_TEST_PATTERN_EN replaces the renderer colour with eight
// vertical colour bars and a one-pixel white border, at the same latency.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 1
) (
    input  logic                 vga_clock,
    input  logic                 reset_n,
    output logic [COORD_X_W-1:0] screenX,
    output logic [COORD_Y_W-1:0] screenY,
    output logic                 refresh,
    input  logic [COLOR_W-1:0]   r_in,
    input  logic [COLOR_W-1:0]   g_in,
    input  logic [COLOR_W-1:0]   b_in,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_active, v_active, h_sync, v_sync;
    logic             active;
    align_t           stage_q;
    align_t           align_dl [PIPE_DELAY];
    align_t           align_out;
    rgb_t             pixel;
    logic             unused_bits;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_counter (
        .clk(vga_clock), .reset_n(reset_n), .enable(1'b1),
        .count(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync)
    );

    // The vertical axis only steps when the line wraps, so (799,524) rolls both to 0 together.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_counter (
        .clk(vga_clock), .reset_n(reset_n), .enable(h_wrap),
        .count(v_cnt), .wrap(v_wrap), .active(v_active), .sync(v_sync)
    );

    assign active = h_active && v_active;

    // Coordinate stage: the renderer and the timing flags both see this cycle's position
    // one edge after the counters reach it; the timing flags then enter the delay line.
    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            screenX <= '0;
            screenY <= '0;
            refresh <= 1'b0;
            stage_q <= '0;
        end else begin
            screenX <= active ? h_cnt : '0;
            screenY <= active ? v_cnt[COORD_Y_W-1:0] : '0;
            refresh <= (h_cnt == '0) && (v_cnt == CNT_W'(V_ACTIVE));
            stage_q <= '{active: active, hs: h_sync, vs: v_sync};
        end
    end

    // Matches the renderer's PIPE_DELAY-cycle colour latency; flushed to blank on reset.
    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) align_dl[i] <= '0;
        end else begin
            align_dl[0] <= stage_q;
            for (int i = 1; i < PIPE_DELAY; i++) align_dl[i] <= align_dl[i-1];
        end
    end

    assign align_out = align_dl[PIPE_DELAY-1];

`ifdef VGA_SYNC_TEST_PATTERN_EN
    rgb_t pattern_now;
    rgb_t pattern_dl [PIPE_DELAY];

    // Pattern is derived from the registered coordinate, so it needs the same
    // PIPE_DELAY stages the renderer would have had to meet the delayed timing flags.
    always_comb begin
        pattern_now = bar_color(bar_index(screenX));
        if ((screenX == '0) || (screenX == COORD_X_W'(H_ACTIVE - 1)) ||
            (screenY == '0) || (screenY == COORD_Y_W'(V_ACTIVE - 1))) begin
            pattern_now = '{r: '1, g: '1, b: '1};
        end
    end

    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) pattern_dl[i] <= '0;
        end else begin
            pattern_dl[0] <= pattern_now;
            for (int i = 1; i < PIPE_DELAY; i++) pattern_dl[i] <= pattern_dl[i-1];
        end
    end

    assign pixel       = pattern_dl[PIPE_DELAY-1];
    assign unused_bits = &{1'b0, v_wrap, v_cnt[CNT_W-1], r_in, g_in, b_in};
`else
    assign pixel       = '{r: r_in, g: g_in, b: b_in};
    assign unused_bits = &{1'b0, v_wrap, v_cnt[CNT_W-1]};
`endif

    // Pin register: colour is gated by the delayed active flag, so renderer data
    // presented during blanking never reaches the pins.
    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else begin
            vga_r  <= align_out.active ? pixel.r : '0;
            vga_g  <= align_out.active ? pixel.g : '0;
            vga_b  <= align_out.active ? pixel.b : '0;
            vga_hs <= align_out.hs ? SYNC_POL : ~SYNC_POL;
            vga_vs <= align_out.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Scoreboard bench for vga_sync_gen, built with a reduced frame geometry so that
// several complete frames, mid-frame resets and frame wraps fit in a short run.
// The reference model works from the number of clock edges since the last reset
// and turns that into a raster position with plain division/modulo.
module tb_vga_sync_gen;

    localparam int   HA = 64, HF = 8, HS = 12, HB = 12;
    localparam int   VA = 24, VF = 3, VS = 2,  VB = 4;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;
    localparam int   PD = 1;
    localparam logic POL = 1'b0;

    typedef struct {
        int x;
        int y;
        bit refresh;
        bit hs;
        bit vs;
        int r;
        int g;
        int b;
        bit win;
    } exp_t;

    logic       vga_clock = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] r_in = '0, g_in = '0, b_in = '0;
    logic [9:0] screenX;
    logic [8:0] screenY;
    logic       refresh;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;

    exp_t sb[$];
    int   since_reset  = 0;
    bit   in_window    = 1'b0;
    int   refresh_seen = 0;
    int   errors = 0;
    int   checks = 0;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .PIPE_DELAY(PD)
    ) dut (
        .vga_clock(vga_clock), .reset_n(reset_n),
        .screenX(screenX), .screenY(screenY), .refresh(refresh),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    always #5 vga_clock = ~vga_clock;

    // Expected outputs just after an edge. cnt counts non-reset edges since the
    // last reset edge: coordinates show raster position cnt-1, pins show cnt-2-PD.
    function automatic exp_t model(input int cnt, input bit rst,
                                   input int r, input int g, input int b);
        exp_t e;
        int   p, h, v;
        e = '{x: 0, y: 0, refresh: 1'b0, hs: ~POL, vs: ~POL, r: 0, g: 0, b: 0, win: 1'b0};
        if (rst) return e;
        p = cnt - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HA && v < VA) begin
            e.x = h;
            e.y = v;
        end
        e.refresh = (h == 0) && (v == VA);
        p = cnt - 2 - PD;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            if (h >= HA + HF && h < HA + HF + HS) e.hs = POL;
            if (v >= VA + VF && v < VA + VF + VS) e.vs = POL;
            if (h < HA && v < VA) begin
`ifdef VGA_SYNC_TEST_PATTERN_EN
                int barR[8] = '{15, 15, 0, 0, 15, 15, 0, 0};
                int barG[8] = '{15, 15, 15, 15, 0, 0, 0, 0};
                int barB[8] = '{15, 0, 15, 0, 15, 0, 15, 0};
                if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
                    e.r = 15; e.g = 15; e.b = 15;
                end else begin
                    e.r = barR[h / 80]; e.g = barG[h / 80]; e.b = barB[h / 80];
                end
`else
                e.r = r; e.g = g; e.b = b;
`endif
            end
        end
        return e;
    endfunction

    // Drives one cycle of stimulus (reset level plus random renderer colour)
    // and queues what the pins must show after the coming edge.
    task automatic applyStimulus(input bit rstN);
        exp_t e;
        @(negedge vga_clock);
        reset_n = rstN;
        r_in = 4'($urandom);
        g_in = 4'($urandom);
        b_in = 4'($urandom);
        if (!rstN) since_reset = 0;
        else since_reset++;
        e = model(since_reset, !rstN, int'(r_in), int'(g_in), int'(b_in));
        e.win = in_window;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every edge the DUT presents a new pixel; compare it to the oldest queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge vga_clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("screenX", int'(screenX), e.x);
                checkOutput("screenY", int'(screenY), e.y);
                checkOutput("refresh", int'(refresh), int'(e.refresh));
                checkOutput("vga_hs",  int'(vga_hs),  int'(e.hs));
                checkOutput("vga_vs",  int'(vga_vs),  int'(e.vs));
                checkOutput("vga_r",   int'(vga_r),   e.r);
                checkOutput("vga_g",   int'(vga_g),   e.g);
                checkOutput("vga_b",   int'(vga_b),   e.b);
                if (e.win && refresh === 1'b1) refresh_seen++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target;
        int guard;
        $display("[TB] start: %0dx%0d active, %0d clocks per frame", HA, VA, FRAME);

        repeat (3) applyStimulus(1'b0);
        repeat (2 * FRAME + 50) applyStimulus(1'b1);

        // Reset mid-frame at the scaled equivalent of (300,200).
        target = 10 * HT + 30;
        guard = 0;
        while ((since_reset % FRAME) != target && guard < FRAME) begin
            applyStimulus(1'b1);
            guard++;
        end
        checkOutput("reach_reset_point", since_reset % FRAME, target);
        applyStimulus(1'b0);

        // Three clean frames after the reset must carry exactly three refresh pulses.
        in_window = 1'b1;
        repeat (3 * FRAME) applyStimulus(1'b1);
        in_window = 1'b0;

        repeat (4) begin
            repeat ($urandom_range(50, 2 * FRAME)) applyStimulus(1'b1);
            applyStimulus(1'b0);
        end
        repeat (FRAME + 10) applyStimulus(1'b1);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge vga_clock);
            guard++;
        end
        #2;
        checkOutput("scoreboard_drained", sb.size(), 0);
        checkOutput("refresh_count", refresh_seen, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
